// File: rtl/ame_pkg.sv
// Shared types and constants for the affine-motion normal-equation accumulator.
package ame_pkg;

   // Frame sequencing states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_FLUSH,
      ST_ISSUE,
      ST_WAIT
   } ame_state_t;

   // Cycles spent draining the two-stage MAC pipeline after the last sample
   localparam int FLUSH_DEPTH = 2;

   // System dimensions: 6 unknowns, 6 matrix columns plus one RHS column
   localparam int MAT_ROWS = 6;
   localparam int MAT_COLS = 7;

endpackage

// File: rtl/ame_grad_mac.sv
// One registered signed multiply followed by an accumulate.
// Optional macro AME_MATRIX_SAT_EN: clamp the accumulator to the signed
// range instead of wrapping in two's complement.
module ame_grad_mac
   import ame_pkg::*;
#(
   parameter int SAMPLE_BITS = 16,
   parameter int ACC_BITS    = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   clr,
   input  logic                   mul_en,
   input  logic                   acc_en,
   input  logic [SAMPLE_BITS-1:0] op_a,
   input  logic [SAMPLE_BITS-1:0] op_b,
   output logic [ACC_BITS-1:0]    acc
);

   logic signed [2*SAMPLE_BITS-1:0] prod_q;
   logic signed [ACC_BITS-1:0]      prod_ext;
   logic        [ACC_BITS-1:0]      sum;
   logic        [ACC_BITS-1:0]      acc_nxt;

   // Stage 1: full-precision product of the incoming operands
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)    prod_q <= '0;
      else if (mul_en) prod_q <= $signed(op_a) * $signed(op_b);
   end

   assign prod_ext = ACC_BITS'(prod_q);
   assign sum      = acc + prod_ext;

`ifdef AME_MATRIX_SAT_EN
   logic ovf_pos;
   logic ovf_neg;

   // Overflow only possible when both addends share a sign the sum lacks
   always_comb begin
      ovf_pos = ~acc[ACC_BITS-1] & ~prod_ext[ACC_BITS-1] &  sum[ACC_BITS-1];
      ovf_neg =  acc[ACC_BITS-1] &  prod_ext[ACC_BITS-1] & ~sum[ACC_BITS-1];
      acc_nxt = sum;
      if (ovf_pos)      acc_nxt = {1'b0, {(ACC_BITS-1){1'b1}}};
      else if (ovf_neg) acc_nxt = {1'b1, {(ACC_BITS-1){1'b0}}};
   end
`else
   assign acc_nxt = sum;
`endif

   // Stage 2: accumulate the registered product; cleared at frame start
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)    acc <= '0;
      else if (clr)    acc <= '0;
      else if (acc_en) acc <= acc_nxt;
   end

endmodule

// File: rtl/ame_matrix_accum.sv
// Accumulates the 6x6 gradient autocorrelation matrix A and the 6-entry
// cross-correlation vector B for affine motion estimation, then hands the
// [A|B] system to an equation solver.
// Optional macro AME_MATRIX_SAT_EN: saturating accumulation (see ame_grad_mac).
// Flat packing: coefficient ck at smp_coef_i[k*SAMPLE_BITS +: SAMPLE_BITS];
// element [i][j] at solve_data_o[(i*7+j)*COMP_DATA_BITS +: COMP_DATA_BITS].
module ame_matrix_accum
   import ame_pkg::*;
#(
   parameter int COMP_DATA_BITS = 64,
   parameter int SAMPLE_BITS    = 16,
   parameter int CNT_BITS       = 12
) (
   input  logic                                         clk_i,
   input  logic                                         rst_n_i,
   input  logic                                         frm_init_i,
   input  logic                                         affine_param6_i,
   input  logic                                         smp_valid_i,
   output logic                                         smp_ready_o,
   input  logic                                         smp_last_i,
   input  logic [6*SAMPLE_BITS-1:0]                     smp_coef_i,
   input  logic [SAMPLE_BITS-1:0]                       smp_resid_i,
   output logic                                         solve_init_o,
   output logic                                         solve_param6_o,
   output logic [MAT_ROWS*MAT_COLS*COMP_DATA_BITS-1:0]  solve_data_o,
   input  logic                                         solve_done_i,
   output logic [CNT_BITS-1:0]                          smp_cnt_o,
   output logic                                         busy_o
);

   ame_state_t state, state_nxt;
   logic [1:0] flush_cnt;
   logic       accept;
   logic       clr;
   logic       prod_vld;

   logic [SAMPLE_BITS-1:0]    coef  [MAT_ROWS];
   logic [COMP_DATA_BITS-1:0] a_acc [MAT_ROWS][MAT_ROWS];
   logic [COMP_DATA_BITS-1:0] b_acc [MAT_ROWS];

   assign accept       = smp_valid_i & smp_ready_o;
   assign clr          = (state == ST_IDLE) & frm_init_i;
   assign smp_ready_o  = (state == ST_ACCUM);
   assign solve_init_o = (state == ST_ISSUE);
   assign busy_o       = (state != ST_IDLE);

   // State register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (frm_init_i)               state_nxt = ST_ACCUM;
         ST_ACCUM: if (accept && smp_last_i)     state_nxt = ST_FLUSH;
         ST_FLUSH: if (flush_cnt == 2'(FLUSH_DEPTH-1)) state_nxt = ST_ISSUE;
         ST_ISSUE:                               state_nxt = ST_WAIT;
         ST_WAIT:  if (solve_done_i)             state_nxt = ST_IDLE;
         default:                                state_nxt = ST_IDLE;
      endcase
   end

   // Counts cycles spent in FLUSH while the MAC pipeline drains
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)               flush_cnt <= '0;
      else if (state == ST_FLUSH) flush_cnt <= flush_cnt + 2'd1;
      else                        flush_cnt <= '0;
   end

   // Model select is captured once per frame
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) solve_param6_o <= 1'b0;
      else if (clr) solve_param6_o <= affine_param6_i;
   end

   // Accepted-sample counter, saturating at all-ones
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                         smp_cnt_o <= '0;
      else if (clr)                         smp_cnt_o <= '0;
      else if (accept && (smp_cnt_o != '1)) smp_cnt_o <= smp_cnt_o + 1'b1;
   end

   // Valid bit travelling alongside the registered products
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) prod_vld <= 1'b0;
      else          prod_vld <= accept;
   end

   // 4-param model drops the c0/c1 terms entirely
   always_comb begin
      for (int k = 0; k < MAT_ROWS; k++) begin
         coef[k] = smp_coef_i[k*SAMPLE_BITS +: SAMPLE_BITS];
         if (k < 2 && !solve_param6_o) coef[k] = '0;
      end
   end

   for (genvar gi = 0; gi < MAT_ROWS; gi++) begin : g_row
      for (genvar gj = 0; gj < MAT_ROWS; gj++) begin : g_col
         if (gj >= gi) begin : g_upper
            ame_grad_mac #(
               .SAMPLE_BITS (SAMPLE_BITS),
               .ACC_BITS    (COMP_DATA_BITS)
            ) u_mac (
               .clk_i   (clk_i),
               .rst_n_i (rst_n_i),
               .clr     (clr),
               .mul_en  (accept),
               .acc_en  (prod_vld),
               .op_a    (coef[gi]),
               .op_b    (coef[gj]),
               .acc     (a_acc[gi][gj])
            );
         end else begin : g_mirror
            // A is symmetric, so the lower triangle reuses the upper one
            assign a_acc[gi][gj] = a_acc[gj][gi];
         end
         assign solve_data_o[(gi*MAT_COLS+gj)*COMP_DATA_BITS +: COMP_DATA_BITS] = a_acc[gi][gj];
      end

      ame_grad_mac #(
         .SAMPLE_BITS (SAMPLE_BITS),
         .ACC_BITS    (COMP_DATA_BITS)
      ) u_bmac (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .clr     (clr),
         .mul_en  (accept),
         .acc_en  (prod_vld),
         .op_a    (coef[gi]),
         .op_b    (smp_resid_i),
         .acc     (b_acc[gi])
      );
      assign solve_data_o[(gi*MAT_COLS+MAT_ROWS)*COMP_DATA_BITS +: COMP_DATA_BITS] = b_acc[gi];
   end

endmodule

// File: doc/ame_matrix_accum.md
AME_MATRIX_ACCUM -- requirements
Module: ame_matrix_accum

Interface
REQ-001 SHALL have parameter COMP_DATA_BITS, default 64, accumulator and output element width.
REQ-002 SHALL have parameter SAMPLE_BITS, default 16, signed gradient-coefficient and residual width.
REQ-003 SHALL have parameter CNT_BITS, default 12, sample-counter width.
REQ-004 clk_i  input  1  clock; all logic on its rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 frm_init_i  input  1  one-cycle pulse that starts a frame; ignored unless IDLE.
REQ-007 affine_param6_i  input  1  model select, sampled on frm_init_i; 1 = 6-param, 0 = 4-param.
REQ-008 smp_valid_i  input  1  sample valid.
REQ-009 smp_ready_o  output  1  sample ready.
REQ-010 smp_last_i  input  1  marks the final sample of the frame.
REQ-011 smp_coef_i  input  6xSAMPLE_BITS  signed coefficients c0..c5.
REQ-012 smp_resid_i  input  SAMPLE_BITS  signed residual r.
REQ-013 solve_init_o  output  1  one-cycle start pulse to the equation solver.
REQ-014 solve_param6_o  output  1  latched model select.
REQ-015 solve_data_o  output  6x7xCOMP_DATA_BITS  system [A|B]; element [i][j<6] = Aij, [i][6] = Bi.
REQ-016 solve_done_i  input  1  solver completion pulse.
REQ-017 smp_cnt_o  output  CNT_BITS  samples accepted in the current frame.
REQ-018 busy_o  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement states IDLE, ACCUM, FLUSH, ISSUE and WAIT.
REQ-020 Transitions SHALL be: IDLE->ACCUM on frm_init_i; ACCUM->FLUSH on an accepted sample with smp_last_i; FLUSH->ISSUE after 2 cycles; ISSUE->WAIT after 1 cycle; WAIT->IDLE on solve_done_i.
REQ-021 smp_ready_o SHALL be 1 only in ACCUM; a sample is accepted when smp_valid_i & smp_ready_o.
REQ-022 On frm_init_i, all accumulators and smp_cnt_o SHALL clear, and affine_param6_i SHALL be latched to solve_param6_o.
REQ-023 Per accepted sample, Aij += ci*cj for i<=j, and Bi += ci*r.
REQ-024 Products SHALL be full-precision 2*SAMPLE_BITS signed, sign-extended to COMP_DATA_BITS.
REQ-025 MAC pipeline: products registered at t+1 and accumulated at t+2 for a sample accepted at cycle t; throughput 1 sample/cycle.
REQ-026 solve_data_o[i][j] for i>j SHALL equal Aji (symmetric mirror, no separate accumulator).
REQ-027 In 4-param mode, c0 and c1 SHALL be treated as 0, so rows/cols 0,1 and B0,B1 read 0.
REQ-028 solve_init_o SHALL pulse in ISSUE, 3 cycles after the last sample was accepted; solve_data_o SHALL be stable from ISSUE until return to IDLE.
REQ-029 smp_cnt_o SHALL saturate at all-ones and not wrap.
REQ-030 smp_valid_i outside ACCUM SHALL have no effect.
REQ-031 frm_init_i outside IDLE SHALL be ignored.
REQ-032 solve_done_i outside WAIT SHALL be ignored.
REQ-033 A frame holds at least one sample; smp_last_i on the first accepted sample is legal.

Reset
REQ-034 Reset, including mid-frame, SHALL force IDLE and zero all accumulators, solve_data_o, smp_cnt_o, solve_init_o, solve_param6_o, smp_ready_o and busy_o.
REQ-035 Pipeline valid bits SHALL clear on reset so that no partial product is accumulated after release.

Configuration
REQ-036 Macro AME_MATRIX_SAT_EN: when defined, each accumulate SHALL clamp to the signed COMP_DATA_BITS max/min on overflow.
REQ-037 When AME_MATRIX_SAT_EN is undefined, accumulation SHALL wrap in two's complement.

Structure
REQ-038 Package ame_pkg SHALL hold the state enum typedef, the FLUSH depth constant (2) and the 6/7 matrix dimension constants.
REQ-039 Sub-module ame_grad_mac SHALL implement one registered multiply plus accumulate (with optional saturation), instantiated 27 times (21 A + 6 B).

Verification
REQ-040 6-param, one sample c={1,2,3,4,5,6}, r=7, last -> A23=12, A55=36, B0=7, B5=42, A32=12; solve_init_o 3 cycles after accept.
REQ-041 4-param, 3 samples each c={9,9,1,1,1,1}, r=2 -> A00=A11=B0=0, A22=3, B2=6, smp_cnt_o=3.
REQ-042 smp_valid_i toggling 1,0,1 with last on the 2nd accept -> exactly 2 samples accumulated; smp_ready_o low from FLUSH onward.
REQ-043 c0=r=-32768 repeated to overflow, macro on -> B0 pins at signed max; macro off -> B0 wraps.
REQ-044 rst_n_i asserted during ACCUM after 5 samples -> outputs zero at once; a new frame of 1 sample gives only that sample's products.
REQ-045 frm_init_i pulse during WAIT -> ignored; solve_done_i -> IDLE, busy_o=0.
